// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues sequential imem requests under a credit limit,
// buffers in-order responses with their PCs, and flushes/refetches on an EX redirect.
module ifetch_queue #(
  parameter int                   ADDR_SIZE  = 32,
  parameter int                   INSTR_SIZE = 32,
  parameter int                   DEPTH      = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_i,
  input  logic [ADDR_SIZE-1:0]  redirect_pc_i,
  input  logic                  stall_i,
  output logic                  imem_req_valid,
  output logic [ADDR_SIZE-1:0]  imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_SIZE-1:0] imem_rsp_data,
  output logic [INSTR_SIZE-1:0] instrF,
  output logic [ADDR_SIZE-1:0]  pcF,
  output logic                  validF
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [INSTR_SIZE-1:0] NOP = INSTR_SIZE'(32'h0000_0013);

  logic [ADDR_SIZE-1:0]  fetch_pc, rsp_pc;
  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count, outstanding, drop_cnt;
  logic [INSTR_SIZE-1:0] instr_mem [DEPTH];
  logic [ADDR_SIZE-1:0]  pc_mem    [DEPTH];

  logic                  fire, rsp_accept, push, pop;
  logic [SUM_W-1:0]      credit_used;
  logic [ADDR_SIZE-1:0]  target_pc;

  // Every slot that is either queued or still in flight holds one credit, so a
  // response always finds room in the queue.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = reset & ~redirect_i & (credit_used < SUM_W'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid & imem_req_ready;

  // Responses with nothing in flight are leftovers from before a reset.
  assign rsp_accept = imem_rsp_valid & (outstanding != '0);
  assign push       = rsp_accept & ~redirect_i & (drop_cnt == '0);
  assign pop        = validF & ~stall_i & ~redirect_i;
  assign target_pc  = redirect_pc_i & ~ADDR_SIZE'(3);

  assign validF = reset & (count != '0);
  assign instrF = validF ? instr_mem[head] : NOP;
  assign pcF    = validF ? pc_mem[head]    : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(rsp_accept);
      if (redirect_i) begin
        // Everything still in flight belongs to the wrong path; one of those
        // responses may be arriving right now and is discarded here.
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        head     <= tail;
        count    <= '0;
        drop_cnt <= outstanding - CNT_W'(rsp_accept);
      end else begin
        if (fire)
          fetch_pc <= fetch_pc + ADDR_SIZE'(4);
        if (rsp_accept && drop_cnt != '0)
          drop_cnt <= drop_cnt - CNT_W'(1);
        if (push) begin
          rsp_pc <= rsp_pc + ADDR_SIZE'(4);
          tail   <= tail + PTR_W'(1);
        end
        if (pop)
          head <= head + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so stale
  // contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= imem_rsp_data;
      pc_mem[tail]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: queue-based reference model plus an
// in-order variable-latency imem responder, directed scenarios then random traffic.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, redirect_i, stall_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic [31:0] instrF, pcF;
  logic        validF;

  always #5 clk = ~clk;

  ifetch_queue #(
    .ADDR_SIZE(32), .INSTR_SIZE(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instrF(instrF), .pcF(pcF), .validF(validF)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { logic [31:0] addr; int due; } req_t;

  // Reference model: queue contents, fetch/response PCs, in-flight and drop counts.
  entry_t      mq[$];
  req_t        pend[$];
  logic [31:0] m_fetch, m_rsp;
  int          m_out, m_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  bit stale    = 1'b0;
  bit rsp_rand = 1'b0;

  function automatic logic [31:0] memfn(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive the imem response for this cycle, then compare DUT outputs to the model.
  task automatic sample();
    bit exp_rv, exp_v;
    if (stale) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (pend.size() > 0 && pend[0].due <= cyc &&
                 (!rsp_rand || $urandom_range(3) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_rv = reset && !redirect_i && (mq.size() + m_out < DEPTH);
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) check("req_addr", imem_req_addr, m_fetch);
    exp_v = reset && (mq.size() > 0);
    check("validF", {31'b0, validF}, {31'b0, exp_v});
    check("instrF", instrF, exp_v ? mq[0].instr : NOP);
    check("pcF", pcF, exp_v ? mq[0].pc : 32'h0);
  endtask

  // Advance the model (and the imem responder) across the rising edge.
  task automatic advance();
    bit fire, acc;
    @(posedge clk);
    if (!reset) begin
      m_fetch = RESET_PC;
      m_rsp   = RESET_PC;
      m_out   = 0;
      m_drop  = 0;
      mq.delete();
      pend.delete();
    end else begin
      fire = !redirect_i && (mq.size() + m_out < DEPTH) && imem_req_ready;
      acc  = imem_rsp_valid && (m_out > 0);
      if (imem_rsp_valid && !stale && pend.size() > 0) void'(pend.pop_front());
      if (fire) pend.push_back('{addr: m_fetch, due: cyc + lat});
      if (redirect_i) begin
        mq.delete();
        m_fetch = redirect_pc_i & ~32'h3;
        m_rsp   = m_fetch;
        m_drop  = m_out - int'(acc);
        m_out   = m_out - int'(acc);
      end else begin
        if (mq.size() > 0 && !stall_i) void'(mq.pop_front());
        if (acc) begin
          if (m_drop > 0) m_drop--;
          else begin
            mq.push_back('{pc: m_rsp, instr: imem_rsp_data});
            m_rsp += 32'd4;
          end
        end
        if (fire) m_fetch += 32'd4;
        m_out = m_out + int'(fire) - int'(acc);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    bit found;
    reset = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    m_fetch = RESET_PC; m_rsp = RESET_PC; m_out = 0; m_drop = 0;
    @(negedge clk);

    // Reset: two cycles low, outputs idle.
    sample();
    check("rst_validF", {31'b0, validF}, 32'd0);
    check("rst_instrF", instrF, NOP);
    check("rst_pcF", pcF, 32'd0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    advance();
    cycle();
    reset = 1'b1;

    // L=1 fill: fire at c0, validF two cycles later, pcF 0,4,8.
    sample();
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    advance();
    sample();
    check("c1_validF", {31'b0, validF}, 32'd0);
    advance();
    sample();
    check("c2_pcF", pcF, 32'h0);
    check("c2_instrF", instrF, memfn(32'h0));
    advance();
    sample();
    check("c3_pcF", pcF, 32'h4);
    advance();

    // Stall for 8 cycles with head pcF=8; queue and credits fill, requests stop.
    stall_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      check("stall_hold_pc", pcF, 32'h8);
      if (i == 7) check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
      advance();
    end
    stall_i = 1'b0;
    repeat (10) cycle();

    // L=3 with requests in flight, redirect to an unaligned target.
    lat = 3;
    repeat (2) cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    cycle();
    redirect_i = 1'b0;
    sample();
    check("redir_addr", imem_req_addr, 32'h100);
    advance();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      sample();
      if (validF) begin
        found = 1'b1;
        check("redir_pcF", pcF, 32'h100);
        check("redir_instrF", instrF, memfn(32'h100));
      end
      advance();
    end
    if (!found) check("redir_timeout", 32'd0, 32'd1);

    // Redirect coinciding with a response and a poppable head.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc && mq.size() > 0) found = 1'b1;
      else cycle();
    end
    if (!found) check("redir_rsp_setup_timeout", 32'd0, 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    cycle();
    redirect_i = 1'b0;
    sample();
    check("redir_rsp_validF", {31'b0, validF}, 32'd0);
    advance();
    repeat (6) cycle();

    // Reset with 3 outstanding, then stale response pulses that must be ignored.
    lat = 5;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out == 3) found = 1'b1;
      else cycle();
    end
    if (!found) check("out3_timeout", 32'd0, 32'd1);
    reset = 1'b0;
    cycle();
    reset = 1'b1; imem_req_ready = 1'b0; stale = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stale_validF", {31'b0, validF}, 32'd0);
      check("stale_addr", imem_req_addr, RESET_PC);
      advance();
    end
    stale = 1'b0; imem_req_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      sample();
      if (validF) begin
        found = 1'b1;
        check("restart_pcF", pcF, RESET_PC);
      end
      advance();
    end
    if (!found) check("restart_timeout", 32'd0, 32'd1);

    // Redirect to the top of the address space; fetch and pcF wrap to 0.
    lat = 1;
    repeat (10) cycle();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    redirect_i = 1'b0;
    sample();
    check("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    advance();
    sample();
    check("wrap_addr1", imem_req_addr, 32'h0);
    advance();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      sample();
      if (validF) begin
        found = 1'b1;
        check("wrap_pcF0", pcF, 32'hFFFF_FFFC);
      end
      advance();
    end
    if (!found) check("wrap_timeout", 32'd0, 32'd1);
    sample();
    check("wrap_pcF1", pcF, 32'h0);
    advance();

    // Random traffic against the model.
    rsp_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(199) != 0);
      redirect_i     = ($urandom_range(19) == 0);
      redirect_pc_i  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : $urandom;
      stall_i        = ($urandom_range(9) < 3);
      imem_req_ready = ($urandom_range(9) < 7);
      lat            = 1 + $urandom_range(3);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
